// File: rtl/sorter.sv
// Streaming insertion sorter: one {data,addr} pair per cycle into N always-sorted slots.
// Define SORTER_DESCENDING_EN to sort largest-first instead of ascending.
module sorter #(
   parameter int N = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       data,
   input  logic [7:0]       addr,
   output logic [8*N-1:0]   sorted_data,
   output logic [8*N-1:0]   sorted_addr
);

   localparam int CW = $clog2(N) + 1;

   logic [7:0]    r_data [N];
   logic [7:0]    r_addr [N];
   logic [N-1:0]  r_valid;
   logic [CW-1:0] r_count;

   logic [N-1:0]  w_take;
   logic [N-1:0]  w_take_prev;
   logic          w_full;

   // A slot at or beyond the insertion point either loads the new pair or shifts up.
   always_comb begin
      w_take = '0;
      for (int i = 0; i < N; i++) begin
`ifdef SORTER_DESCENDING_EN
         w_take[i] = !r_valid[i] || (r_data[i] < data);
`else
         w_take[i] = !r_valid[i] || (r_data[i] > data);
`endif
      end
   end

   assign w_take_prev = {w_take[N-2:0], 1'b0};
   assign w_full      = (r_count == CW'(N));

   // Slot array and element count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            r_data[i] <= 8'hFF;
            r_addr[i] <= 8'hFF;
         end
         r_valid <= '0;
         r_count <= '0;
      end else if (!w_full) begin
         for (int i = 0; i < N; i++) begin
            if (w_take[i] && !w_take_prev[i]) begin
               r_data[i]  <= data;
               r_addr[i]  <= addr;
               r_valid[i] <= 1'b1;
            end else if (w_take[i] && (i != 0)) begin
               r_data[i]  <= r_data[(i == 0) ? 0 : i-1];
               r_addr[i]  <= r_addr[(i == 0) ? 0 : i-1];
               r_valid[i] <= r_valid[(i == 0) ? 0 : i-1];
            end else begin
               r_data[i]  <= r_data[i];
               r_addr[i]  <= r_addr[i];
               r_valid[i] <= r_valid[i];
            end
         end
         r_count <= r_count + CW'(1);
      end else begin
         r_count <= r_count;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign sorted_data[8*g +: 8] = r_data[g];
      assign sorted_addr[8*g +: 8] = r_addr[g];
   end

endmodule

// File: tb/tb_sorter.sv
// Self-checking bench for sorter: directed and random streams against a rank-based model.
module tb_sorter;

   localparam int N = 64;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [7:0]     data = 8'h00;
   logic [7:0]     addr = 8'h00;
   logic [8*N-1:0] sorted_data;
   logic [8*N-1:0] sorted_addr;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_d[$];
   logic [7:0] m_a[$];
   logic [7:0] exp_d [N];
   logic [7:0] exp_a [N];
   logic [7:0] src [256];
   int         seen [N];

   sorter #(.N(N)) dut (
      .clk(clk), .rst(rst), .data(data), .addr(addr),
      .sorted_data(sorted_data), .sorted_addr(sorted_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int idx, input logic [7:0] got, input logic [7:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s[%0d]: got %h expected %h", tag, idx, got, want);
      end
   endtask

   // expected slot = stable rank of each accepted element
   task automatic build_expected();
      for (int s = 0; s < N; s++) begin
         exp_d[s] = 8'hFF;
         exp_a[s] = 8'hFF;
      end
      for (int k = 0; k < m_d.size(); k++) begin
         int r = 0;
         for (int j = 0; j < m_d.size(); j++) begin
`ifdef SORTER_DESCENDING_EN
            if (m_d[j] > m_d[k] || (m_d[j] == m_d[k] && j < k)) r++;
`else
            if (m_d[j] < m_d[k] || (m_d[j] == m_d[k] && j < k)) r++;
`endif
         end
         exp_d[r] = m_d[k];
         exp_a[r] = m_a[k];
      end
   endtask

   task automatic check_model(input string tag);
      build_expected();
      for (int s = 0; s < N; s++) begin
         chk({tag, "_d"}, s, sorted_data[8*s +: 8], exp_d[s]);
         chk({tag, "_a"}, s, sorted_addr[8*s +: 8], exp_a[s]);
      end
   endtask

   task automatic step(input logic [7:0] d, input logic [7:0] a);
      data = d;
      addr = a;
      @(posedge clk);
      if (rst && m_d.size() < N) begin
         m_d.push_back(d);
         m_a.push_back(a);
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b0;
      repeat (cycles) @(posedge clk);
      m_d.delete();
      m_a.delete();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [7:0] v;

      // reset held, then released with no edge yet
      do_reset(3);
      check_model("reset");
      for (int s = 0; s < N; s++) chk("reset_ff", s, sorted_data[8*s +: 8] & sorted_addr[8*s +: 8], 8'hFF);

      // duplicates keep arrival order
      step(8'h05, 8'd0); step(8'h03, 8'd1); step(8'h05, 8'd2); step(8'h03, 8'd3);
      check_model("dup");
`ifndef SORTER_DESCENDING_EN
      chk("dup_d", 0, sorted_data[7:0],   8'h03); chk("dup_a", 0, sorted_addr[7:0],   8'd1);
      chk("dup_d", 1, sorted_data[15:8],  8'h03); chk("dup_a", 1, sorted_addr[15:8],  8'd3);
      chk("dup_d", 2, sorted_data[23:16], 8'h05); chk("dup_a", 2, sorted_addr[23:16], 8'd0);
      chk("dup_d", 3, sorted_data[31:24], 8'h05); chk("dup_a", 3, sorted_addr[31:24], 8'd2);
`endif

      // extreme values, FF must not be mistaken for empty
      do_reset(1);
      step(8'hFF, 8'd0); step(8'h00, 8'd1); step(8'hFF, 8'd2); step(8'h80, 8'd3);
      check_model("edge");
`ifndef SORTER_DESCENDING_EN
      chk("edge_d", 0, sorted_data[7:0],   8'h00); chk("edge_a", 0, sorted_addr[7:0],   8'd1);
      chk("edge_d", 1, sorted_data[15:8],  8'h80); chk("edge_a", 1, sorted_addr[15:8],  8'd3);
      chk("edge_d", 2, sorted_data[23:16], 8'hFF); chk("edge_a", 2, sorted_addr[23:16], 8'd0);
      chk("edge_d", 3, sorted_data[31:24], 8'hFF); chk("edge_a", 3, sorted_addr[31:24], 8'd2);
`endif

      // random fill, tag integrity, then overflow
      do_reset(1);
      for (int i = 0; i < N; i++) begin
         v = 8'($urandom_range(0, 255));
         src[i] = v;
         step(v, 8'(i));
      end
      check_model("rand");
      for (int i = 0; i < N; i++) seen[i] = 0;
      for (int s = 0; s < N; s++) begin
         chk("rand_src", s, src[sorted_addr[8*s +: 8]], sorted_data[8*s +: 8]);
         if (sorted_addr[8*s +: 8] < 8'(N)) seen[sorted_addr[8*s +: 8]]++;
      end
      for (int i = 0; i < N; i++) chk("rand_tag_once", i, 8'(seen[i]), 8'd1);
      for (int i = 0; i < 10; i++) step(8'h00, 8'(100 + i));
      check_model("overflow");

      // descending and ascending input streams
      do_reset(1);
      for (int i = N - 1; i >= 0; i--) step(8'(i), 8'(i));
      check_model("desc_in");
      do_reset(1);
      for (int i = 0; i < N; i++) step(8'(i), 8'(i));
      check_model("asc_in");
`ifndef SORTER_DESCENDING_EN
      for (int s = 0; s < N; s++) chk("asc_in_direct", s, sorted_data[8*s +: 8], 8'(s));
`endif

      // reset in the middle of a fill
      do_reset(1);
      for (int i = 0; i < 20; i++) step(8'($urandom_range(0, 255)), 8'(i));
      check_model("mid20");
      do_reset(1);
      check_model("mid_reset");
      for (int i = 0; i < N; i++) step(8'($urandom_range(0, 15)), 8'(i));
      check_model("refill");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sorter.md
Name: sorter

Overview:
- Streaming insertion sorter: accepts one 8-bit value plus its 8-bit address tag per clock and keeps a register array of up to N entries sorted at all times.
- Full sorted contents, with matching address tags, are exposed every cycle on two packed output buses.
- Sits behind a memory/address sequencer; after N active cycles the outputs hold the fully sorted data set and where each element came from.

Parameters:
- N, 64, number of sort slots / elements accepted; legal range 2..256 (addr is 8 bits).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low.
- data  input  8  unsigned value to insert this cycle.
- addr  input  8  tag stored alongside data (source address).
- sorted_data  output  8*N  packed slot values; slot i occupies bits [8*i+7 : 8*i]; slot 0 holds the smallest value.
- sorted_addr  output  8*N  packed slot tags, same slot layout as sorted_data.

Behaviour:
- State per slot i: data_q[i] (8b), addr_q[i] (8b), valid_q[i] (1b). Also count (log2(N)+1 bits) holds the number of accepted elements.
- Reset (rst==0 at rising edge):
  - all data_q = 8'hFF, addr_q = 8'hFF, valid_q = 0, count = 0;
  - outputs therefore read all-ones.
  - Reset mid-operation discards all contents; sorting restarts from empty on the next active edge.
- Active cycle (rst==1, count<N): the {data,addr} pair sampled at the edge is inserted and count increments.
  - Outputs are registered: the inserted element is visible after that edge (1-cycle latency, no combinational input-to-output path).
- Insertion rule, evaluated in parallel for every slot; gt[i] = valid_q[i] && (data_q[i] > data):
  - gt[i]==0 and valid_q[i]: slot i holds.
  - gt[i]==1, or !valid_q[i] with i==0 or valid_q[i-1]: this is the insertion point when (i==0 or !gt[i-1]), so the slot loads the new data/addr with valid=1.
  - Otherwise, when gt[i-1] or the slot is beyond the insertion point: slot i loads slot i-1's contents (shift up by one).
  - Slot N-1 contents are never lost, because the array is not full when an insert occurs.
- Ordering: ascending by unsigned data. Ties are stable: a new value equal to existing entries is placed after all of them, so earlier arrivals keep lower slot indices.
- Empty slots always sit above all valid slots and keep 8'hFF/8'hFF.
- Full (count==N): further inputs are ignored; contents and count hold until reset.
- Input data of 8'hFF sorts correctly; validity comes only from valid_q, never from the data value.
- No handshake: every non-reset cycle below full is an insert; the upstream source must present one new element per cycle.

Optional Feature:
- Macro SORTER_DESCENDING_EN.
- Defined: sort order becomes descending (slot 0 = largest); the comparison in gt[i] becomes data_q[i] < data. Ties remain stable, and empty-slot reset value and full behaviour are unchanged.
- Undefined (default): ascending order as specified above.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> every sorted_data/sorted_addr byte = 8'hFF; release, no input edge yet -> still all 8'hFF.
- Random 64: feed 64 random bytes with addr 0..63 on consecutive cycles -> after 64 edges sorted_data equals the software-sorted list ascending; each sorted_addr[i] indexes an input byte equal to sorted_data[i]; all tags 0..63 appear exactly once.
- Duplicates/stability: input 0x05 @addr0, 0x03 @1, 0x05 @2, 0x03 @3 -> slots 0..3 = 03/1, 03/3, 05/0, 05/2.
- Edge values and ordering:
  - input 0xFF, 0x00, 0xFF, 0x80 -> slots 00, 80, FF, FF with tags 1, 3, 0, 2;
  - descending 63..0 input and ascending 0..63 input both yield 0..63.
- Overflow: after 64 inserts, drive data=0x00 for 10 more cycles -> outputs unchanged.
- Reset mid-run: after 20 inserts assert rst=0 for one cycle -> all 8'hFF; resume and insert 64 values -> correct full sort.
